mul_scan_ctrl: RTL
==================

Name: mul_scan_ctrl

Overview:
- Sequencer for the byte-stream mul( parser: walks a byte buffer in memory and feeds one byte per cycle to the parser.
- Filters the parser's products through do()/don't() gating when mode=1, accumulates the accepted products and reports completion.
- Sits between the input buffer RAM (1-cycle read latency) and the parser. The parser's clock-enable and reset are owned by this block.

Parameters:
- LEN_W, 16: width of length and memory address.
- SUM_W, 48: accumulator width; sum wraps modulo 2^SUM_W.
- CNT_W, 16: accepted-product counter width; wraps.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin a scan; sampled only in IDLE.
- length  in  LEN_W  byte count, latched on start.
- mode  in  1  0 = accept all products; 1 = honour do()/don't(). Latched on start.
- mem_rd_en  out  1  buffer read strobe.
- mem_addr  out  LEN_W  buffer read address.
- mem_rdata  in  8  buffer data, valid the cycle after mem_rd_en.
- proc_byte  out  8  byte to parser, = mem_rdata (combinational).
- proc_en  out  1  parser enable, = mem_rd_en delayed one cycle.
- proc_rst_n  out  1  parser reset, = rst_n AND (state != INIT).
- proc_data  in  32  parser product.
- proc_valid  in  1  parser product valid. It is a level: it can stay high across many bytes and is not cleared by parser reset.
- busy  out  1  high in INIT/RUN/DRAIN.
- done  out  1  one-cycle pulse at end of scan.
- sum  out  SUM_W  accumulated total; held after done until next INIT.
- mul_count  out  CNT_W  number of accepted products.

Behaviour:
- Reset: state=IDLE, mem_rd_en=0, mem_addr=0, proc_en=0, busy=0, done=0, sum=0, mul_count=0, gate=1, history cleared, valid_q=1.
- IDLE:
  - start=1 with length!=0 → INIT.
  - start=1 with length==0 → DONE; sum and mul_count are cleared to 0.
  - start while busy is ignored.
- INIT (1 cycle): proc_rst_n=0; sum=0, mul_count=0, addr=0, gate=1, 7-byte history cleared to 0x00, valid_q<=1. → RUN.
- RUN:
  - Each cycle: mem_rd_en=1, mem_addr=addr, addr++.
  - The cycle issuing addr==length-1 is the last RUN cycle. → DRAIN.
- DRAIN: exactly 2 cycles.
  - Cycle 1 feeds the last byte.
  - Cycle 2 observes the last product. → DONE.
- DONE: done=1 for one cycle, busy=0. → IDLE.
- Latency: start at cycle T → done at T+length+4 (T+1 for length 0).
- Gate tracking, on every cycle with proc_en=1:
  - Shift proc_byte into the 7-byte history.
  - If the last 4 bytes are "do()", gate<=1.
  - If the last 7 bytes are "don't()", gate<=0.
  - The two patterns cannot complete on the same byte.
- Product acceptance:
  - Only in RUN/DRAIN, on edge = proc_valid AND NOT valid_q.
  - Accept if mode==0 OR gate==1.
  - On accept: sum += zero-extended proc_data, mul_count += 1.
  - valid_q <= proc_valid every RUN/DRAIN cycle. Setting valid_q=1 in INIT suppresses a stale high proc_valid left over from the previous scan.
- A don't()/do() ')' and a mul ')' never coincide, so the gate value at the valid edge is the gate after the preceding bytes.
- Reset mid-operation: everything returns to reset values, done is not pulsed, and the parser is reset via proc_rst_n. A new start behaves normally.

Test Plan:
- "mul(2,4)", length 8, mode 0, start at T:
  - INIT at T+1; mem_rd_en T+2..T+9; DRAIN T+10..T+11; done at T+12.
  - sum=8, mul_count=1.
- "xmul(2,4)&mul[3,7]!^don't()_mul(5,5)+mul(32,64](mul(11,8)undo()?mul(8,5))":
  - mode 1 → sum=48, mul_count=2.
  - mode 0 → sum=161, mul_count=4.
- length 0 with start → done at T+1, sum=0, mul_count=0, no mem_rd_en.
- Run "mul(3,3)" (sum 9), then run "xx" → sum=0 (stale proc_valid not counted), then run "mul(3,3)" → sum=9.
- SUM_W=32, "mul(65535,65535)mul(65535,65535)" → sum=4294705154 (wrapped), mul_count=2.
- Mid-RUN cases:
  - rst_n low mid-RUN → busy=0, no done, sum=0; subsequent "mul(2,4)" run → sum=8.
  - start pulsed during RUN → ignored; the current scan completes unchanged.

Source files
------------

// File: rtl/mul_scan_ctrl.sv
// Scan sequencer for the mul( byte-stream parser: streams the input buffer one byte
// per cycle, tracks do()/don't() gating and accumulates the accepted products.
module mul_scan_ctrl #(
    parameter int unsigned LEN_W = 16,
    parameter int unsigned SUM_W = 48,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    input  logic             mode,
    output logic             mem_rd_en,
    output logic [LEN_W-1:0] mem_addr,
    input  logic [7:0]       mem_rdata,
    output logic [7:0]       proc_byte,
    output logic             proc_en,
    output logic             proc_rst_n,
    input  logic [31:0]      proc_data,
    input  logic             proc_valid,
    output logic             busy,
    output logic             done,
    output logic [SUM_W-1:0] sum,
    output logic [CNT_W-1:0] mul_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DRAIN1,
        S_DRAIN2,
        S_DONE
    } state_t;

    localparam logic [31:0] DO_PAT   = "do()";
    localparam logic [55:0] DONT_PAT = "don't()";

    state_t           state_q, state_d;
    logic [LEN_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             mode_q, mode_d;
    logic             gate_q, gate_d;
    logic             valid_q, valid_d;
    logic             proc_en_q;
    logic [55:0]      hist_q, hist_d;
    logic [55:0]      hist_shift;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rd_en;
    logic             scanning;
    logic             accept;

    assign hist_shift = {hist_q[47:0], proc_byte};
    assign scanning   = (state_q == S_RUN) || (state_q == S_DRAIN1) || (state_q == S_DRAIN2);
    // Rising edge of the level-style valid; gate already reflects all earlier bytes.
    assign accept     = scanning && proc_valid && !valid_q && (!mode_q || gate_q);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        mode_d  = mode_q;
        gate_d  = gate_q;
        valid_d = valid_q;
        hist_d  = hist_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        rd_en   = 1'b0;

        if (proc_en_q) begin
            hist_d = hist_shift;
            if (hist_shift[31:0] == DO_PAT) begin
                gate_d = 1'b1;
            end else if (hist_shift == DONT_PAT) begin
                gate_d = 1'b0;
            end
        end

        if (scanning) begin
            valid_d = proc_valid;
            if (accept) begin
                sum_d = sum_q + SUM_W'(proc_data);
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d  = length;
                    mode_d = mode;
                    if (length != '0) begin
                        state_d = S_INIT;
                    end else begin
                        state_d = S_DONE;
                        sum_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            S_INIT: begin
                sum_d   = '0;
                cnt_d   = '0;
                addr_d  = '0;
                gate_d  = 1'b1;
                hist_d  = '0;
                valid_d = 1'b1;
                state_d = S_RUN;
            end
            S_RUN: begin
                rd_en  = 1'b1;
                addr_d = addr_q + LEN_W'(1);
                if (addr_q == len_q - LEN_W'(1)) begin
                    state_d = S_DRAIN1;
                end
            end
            S_DRAIN1: state_d = S_DRAIN2;
            S_DRAIN2: state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            mode_q    <= 1'b0;
            gate_q    <= 1'b1;
            valid_q   <= 1'b1;
            hist_q    <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            proc_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            gate_q    <= gate_d;
            valid_q   <= valid_d;
            hist_q    <= hist_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            proc_en_q <= rd_en;
        end
    end

    assign mem_rd_en  = rd_en;
    assign mem_addr   = addr_q;
    assign proc_byte  = mem_rdata;
    assign proc_en    = proc_en_q;
    assign proc_rst_n = rst_n & (state_q != S_INIT);
    assign busy       = scanning || (state_q == S_INIT);
    assign done       = (state_q == S_DONE);
    assign sum        = sum_q;
    assign mul_count  = cnt_q;

endmodule
